load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/rv_mem_pkg.sv | 35 +++
 rtl/load_extend.sv | 34 +++
 rtl/load_align_unit.sv | 110 +++++++++++
 tb/tb_load_align_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the load path: funct3 load codes, FSM states,
// default WAIT timeout and the legality/alignment check used at request time.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    LdB  = 3'b000,
    LdH  = 3'b001,
    LdW  = 3'b010,
    LdBu = 3'b100,
    LdHu = 3'b101
  } load_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } load_state_e;

  localparam int unsigned DefaultTimeoutCycles = 15;

  // True when the code is a legal load and the address is naturally aligned for it.
  function automatic logic load_ok(input logic [2:0] src, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (src)
      LdB, LdBu: ok = 1'b1;
      LdH, LdHu: ok = ~addr_lo[0];
      LdW:       ok = (addr_lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane selection and sign/zero extension of a little-endian
// memory word according to the load code and the low address bits.
module load_extend
  import rv_mem_pkg::*;
(
  input  logic [2:0]  loadSrc,
  input  logic [1:0]  addr,
  input  logic [31:0] memReadData,
  output logic [31:0] result
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = memReadData >> {addr, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = addr[1] ? memReadData[31:16] : memReadData[15:0];
  end

  always_comb begin
    result = '0;
    unique case (loadSrc)
      LdB:     result = {{24{w_byte[7]}}, w_byte};
      LdBu:    result = {24'h000000, w_byte};
      LdH:     result = {{16{w_half[15]}}, w_half};
      LdHu:    result = {16'h0000, w_half};
      LdW:     result = memReadData;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// Load unit: issues one word-aligned memory read per request, waits with a
// timeout, then returns the aligned/extended data or a one-cycle error pulse.
module load_align_unit
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        loadReq,
  input  logic [2:0]  loadSrc,
  input  logic [31:0] loadAddress,
  output logic        memReadReq,
  output logic [31:0] memAddr,
  input  logic        memReadValid,
  input  logic [31:0] memReadData,
  output logic [31:0] loadData,
  output logic        loadDone,
  output logic        loadError,
  output logic        busy
);

  localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);

  load_state_e r_state, w_state_d;
  logic [7:0]  r_count, w_count_d, w_count_inc;
  logic [31:0] r_data, w_data_d;
  logic [2:0]  r_src;
  logic [31:0] r_addr;
  logic        r_error;
  logic        w_accept;
  logic [31:0] w_ext;

  load_extend u_load_extend (
    .loadSrc     (r_src),
    .addr        (r_addr[1:0]),
    .memReadData (memReadData),
    .result      (w_ext)
  );

  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_data_d    = r_data;
    w_accept    = 1'b0;
    w_count_inc = r_count + 8'd1;
    case (r_state)
      StIdle: begin
        if (loadReq) begin
          if (load_ok(loadSrc, loadAddress[1:0])) begin
            w_state_d = StWait;
            w_count_d = '0;
            w_accept  = 1'b1;
          end else begin
            w_state_d = StErr;
          end
        end
      end
      StWait: begin
        // A response in the final WAIT cycle takes priority over the timeout.
        if (memReadValid) begin
          w_data_d  = w_ext;
          w_state_d = StDone;
        end else begin
          w_count_d = w_count_inc;
          if (w_count_inc == TimeoutLimit) begin
            w_state_d = StErr;
          end
        end
      end
      StDone: w_state_d = StIdle;
      StErr: begin
        w_data_d  = '0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_count <= '0;
      r_data  <= '0;
      r_src   <= '0;
      r_addr  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_data  <= w_data_d;
      // Error pulse lines up with loadData being cleared on leaving ERR.
      r_error <= (r_state == StErr);
      if (w_accept) begin
        r_src  <= loadSrc;
        r_addr <= loadAddress;
      end
    end
  end

  always_comb begin
    memReadReq = (r_state == StWait);
    memAddr    = {r_addr[31:2], 2'b00};
    loadDone   = (r_state == StDone);
    loadError  = r_error;
    busy       = (r_state != StIdle);
    loadData   = r_data;
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: hand-computed vectors for extension,
// alignment errors, timeout, mid-WAIT reset and response-vs-timeout priority.
module tb_load_align_unit;

  logic        clk;
  logic        reset;
  logic        loadReq;
  logic [2:0]  loadSrc;
  logic [31:0] loadAddress;
  logic        memReadReq;
  logic [31:0] memAddr;
  logic        memReadValid;
  logic [31:0] memReadData;
  logic [31:0] loadData;
  logic        loadDone;
  logic        loadError;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int req_cnt;

  load_align_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .loadReq      (loadReq),
    .loadSrc      (loadSrc),
    .loadAddress  (loadAddress),
    .memReadReq   (memReadReq),
    .memAddr      (memAddr),
    .memReadValid (memReadValid),
    .memReadData  (memReadData),
    .loadData     (loadData),
    .loadDone     (loadDone),
    .loadError    (loadError),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Drives a one-cycle request; returns one cycle later (cycle 1 of the load).
  task automatic issue(input logic [2:0] src, input logic [31:0] addr);
    loadReq     = 1'b1;
    loadSrc     = src;
    loadAddress = addr;
    tick();
    loadReq     = 1'b0;
  endtask

  // Request, memory answers in the first WAIT cycle, check done cycle result.
  task automatic simple_load(input string tag, input logic [2:0] src, input logic [31:0] addr,
                             input logic [31:0] mem, input logic [31:0] exp);
    issue(src, addr);
    chk({tag, "_memreq"}, {31'd0, memReadReq}, 32'd1);
    memReadValid = 1'b1;
    memReadData  = mem;
    tick();
    memReadValid = 1'b0;
    chk({tag, "_done"}, {31'd0, loadDone}, 32'd1);
    chk({tag, "_data"}, loadData, exp);
    tick();
  endtask

  initial begin
    reset        = 1'b1;
    loadReq      = 1'b0;
    loadSrc      = 3'b000;
    loadAddress  = '0;
    memReadValid = 1'b0;
    memReadData  = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_memreq", {31'd0, memReadReq}, 32'd0);
    chk("rst_done",   {31'd0, loadDone},   32'd0);
    chk("rst_error",  {31'd0, loadError},  32'd0);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_data",   loadData,            32'd0);

    // lb 0x1003, memory answers one cycle after memReadReq.
    issue(3'b000, 32'h0000_1003);
    chk("lb_memreq_c1", {31'd0, memReadReq}, 32'd1);
    chk("lb_memaddr",   memAddr, 32'h0000_1000);
    chk("lb_busy_c1",   {31'd0, busy}, 32'd1);
    loadReq = 1'b1;  // ignored outside IDLE
    loadSrc = 3'b011;
    tick();
    loadReq = 1'b0;
    chk("lb_done_c2", {31'd0, loadDone}, 32'd0);
    chk("lb_err_c2",  {31'd0, loadError}, 32'd0);
    memReadValid = 1'b1;
    memReadData  = 32'h80FF_0000;
    tick();
    memReadValid = 1'b0;
    chk("lb_done_c3", {31'd0, loadDone}, 32'd1);
    chk("lb_data",    loadData, 32'hFFFF_FF80);
    tick();
    chk("lb_done_c4", {31'd0, loadDone}, 32'd0);
    chk("lb_busy_c4", {31'd0, busy}, 32'd0);
    chk("lb_hold",    loadData, 32'hFFFF_FF80);

    simple_load("lhu",  3'b101, 32'h0000_2002, 32'hBEEF_1234, 32'h0000_BEEF);
    simple_load("lh",   3'b001, 32'h0000_2002, 32'hBEEF_1234, 32'hFFFF_BEEF);
    simple_load("lh_lo", 3'b001, 32'h0000_2000, 32'hBEEF_1234, 32'h0000_1234);
    simple_load("lbu1", 3'b100, 32'h0000_1001, 32'h80FF_0000, 32'h0000_0000);
    simple_load("lb2",  3'b000, 32'h0000_1002, 32'h1234_5678, 32'h0000_0034);
    simple_load("lbu3", 3'b100, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
    simple_load("lw",   3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // lw with no response: 15 WAIT cycles then the error pulse.
    issue(3'b010, 32'h0000_4000);
    req_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (memReadReq) req_cnt++;
      tick();
    end
    chk("to_memreq_cycles", req_cnt, 32'd15);
    chk("to_memreq_off",    {31'd0, memReadReq}, 32'd0);
    chk("to_err_early",     {31'd0, loadError}, 32'd0);
    tick();
    chk("to_err",     {31'd0, loadError}, 32'd1);
    chk("to_data",    loadData, 32'd0);
    chk("to_nodone",  {31'd0, loadDone}, 32'd0);
    tick();
    chk("to_err_off", {31'd0, loadError}, 32'd0);

    // Misaligned lw, illegal code, odd lh: error in cycle 2, never a memory request.
    issue(3'b010, 32'h0000_3001);
    chk("mis_memreq_c1", {31'd0, memReadReq}, 32'd0);
    chk("mis_err_c1",    {31'd0, loadError}, 32'd0);
    tick();
    chk("mis_err_c2",    {31'd0, loadError}, 32'd1);
    chk("mis_memreq_c2", {31'd0, memReadReq}, 32'd0);
    tick();
    chk("mis_err_c3",    {31'd0, loadError}, 32'd0);
    issue(3'b011, 32'h0000_3000);
    chk("ill_memreq_c1", {31'd0, memReadReq}, 32'd0);
    tick();
    chk("ill_err_c2",    {31'd0, loadError}, 32'd1);
    tick();
    issue(3'b101, 32'h0000_2001);
    chk("lhu_odd_memreq", {31'd0, memReadReq}, 32'd0);
    tick();
    chk("lhu_odd_err",    {31'd0, loadError}, 32'd1);
    tick();

    // Reset in the 3rd WAIT cycle, late response must be dropped.
    simple_load("pre_rst", 3'b100, 32'h0000_1001, 32'h0000_AB00, 32'h0000_00AB);
    issue(3'b010, 32'h0000_5000);
    tick();
    tick();
    chk("mr_memreq_w3", {31'd0, memReadReq}, 32'd1);
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    memReadValid = 1'b1;
    memReadData  = 32'h1111_1111;
    chk("mr_memreq", {31'd0, memReadReq}, 32'd0);
    chk("mr_busy",   {31'd0, busy}, 32'd0);
    chk("mr_data",   loadData, 32'd0);
    chk("mr_err",    {31'd0, loadError}, 32'd0);
    tick();
    memReadValid = 1'b0;
    chk("mr_nodone", {31'd0, loadDone}, 32'd0);
    chk("mr_data2",  loadData, 32'd0);
    simple_load("mr_next", 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Response coincident with the 15th WAIT cycle wins over the timeout.
    issue(3'b010, 32'h0000_7000);
    for (int i = 0; i < 14; i++) tick();
    chk("race_memreq_w15", {31'd0, memReadReq}, 32'd1);
    memReadValid = 1'b1;
    memReadData  = 32'h0BAD_F00D;
    tick();
    memReadValid = 1'b0;
    chk("race_done", {31'd0, loadDone}, 32'd1);
    chk("race_data", loadData, 32'h0BAD_F00D);
    chk("race_err",  {31'd0, loadError}, 32'd0);
    tick();
    chk("race_err2", {31'd0, loadError}, 32'd0);
    chk("race_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
